// File: rtl/guarded_mode_fsm.sv
// Guarded mode controller: walks IDLE <-> OP1..OPk one neighbour at a time,
// counts rejected requests and latches FAULT after MAX_ERR of them.
module guarded_mode_fsm #(
   parameter int STATE_W    = 3,
   parameter int NUM_STATES = 6,
   parameter int MAX_ERR    = 4,
   parameter int ERR_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   input  logic [STATE_W-1:0] req_state,
   output logic               req_ready,
   input  logic               clr_fault,
   output logic [STATE_W-1:0] state_out,
   output logic               rej,
   output logic [ERR_W-1:0]   err_cnt,
   output logic               fault
);

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = STATE_W'(0),
      S_FAULT = STATE_W'(NUM_STATES-1)
   } state_t;

   // One extra bit so range checks never wrap, even when NUM_STATES == 2**STATE_W.
   localparam logic [STATE_W:0]   NS_EXT  = (STATE_W+1)'(NUM_STATES);
   localparam logic [ERR_W-1:0]   ERR_MAX = ERR_W'(MAX_ERR);
   localparam logic [ERR_W-1:0]   ERR_SAT = '1;

   state_t             state;
   logic               ready_q;
   logic               rej_q;
   logic               fault_q;
   logic [ERR_W-1:0]   err_q;

   logic [STATE_W:0]   st_ext;
   logic [STATE_W:0]   rq_ext;
   logic               st_encoded;
   logic               legal;
   logic [ERR_W-1:0]   err_inc;

   assign st_ext     = {1'b0, state};
   assign rq_ext     = {1'b0, req_state};
   assign st_encoded = st_ext < NS_EXT;
   assign err_inc    = (err_q == ERR_SAT) ? err_q : err_q + 1'b1;

   // Neighbour rule: from IDLE any OP; from an OP only IDLE or an adjacent OP.
   always_comb begin
      legal = 1'b0;
      if (rq_ext >= NS_EXT || req_state == S_FAULT || req_state == state)
         legal = 1'b0;
      else if (state == S_IDLE)
         legal = 1'b1;
      else
         legal = (req_state == S_IDLE) || (rq_ext == st_ext + 1'b1) ||
                 (rq_ext + 1'b1 == st_ext);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ready_q <= 1'b1;
         rej_q   <= 1'b0;
         fault_q <= 1'b0;
         err_q   <= '0;
      end else begin
         rej_q <= 1'b0;
         if (!st_encoded) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
            ready_q <= 1'b0;
         end else if (state == S_FAULT) begin
            ready_q <= 1'b0;
            if (clr_fault) begin
               state   <= S_IDLE;
               err_q   <= '0;
               fault_q <= 1'b0;
               ready_q <= 1'b1;
            end
         end else if (req_valid && ready_q) begin
            // Ready drops for one cycle after every accept, so rej can't repeat.
            ready_q <= 1'b0;
            if (legal) begin
               state <= state_t'(req_state);
            end else begin
               rej_q <= 1'b1;
               err_q <= err_inc;
               if (err_inc == ERR_MAX) begin
                  state   <= S_FAULT;
                  fault_q <= 1'b1;
               end
            end
         end else begin
            ready_q <= 1'b1;
         end
      end
   end

   assign state_out = state;
   assign req_ready = ready_q;
   assign rej       = rej_q;
   assign err_cnt   = err_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_guarded_mode_fsm.sv
// Directed vector bench for guarded_mode_fsm: default build (a) and an
// eight-state build (b) driven from hand-computed tables and sequences.
module tb_guarded_mode_fsm;

   typedef struct {
      logic       rst_n;
      logic       v;
      logic [2:0] rs;
      logic       clr;
      logic [2:0] st;
      logic       rdy;
      logic       rej;
      logic [3:0] err;
      logic       flt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 0, v_a = 0, clr_a = 0;
   logic [2:0] rs_a = '0;
   logic [2:0] st_a;
   logic       rdy_a, rej_a, flt_a;
   logic [3:0] err_a;

   logic       rst_b = 0, v_b = 0, clr_b = 0;
   logic [2:0] rs_b = '0;
   logic [2:0] st_b;
   logic       rdy_b, rej_b, flt_b;
   logic [3:0] err_b;

   int passed = 0;
   int total  = 0;

   guarded_mode_fsm dut_a (
      .clk(clk), .rst_n(rst_a), .req_valid(v_a), .req_state(rs_a),
      .req_ready(rdy_a), .clr_fault(clr_a), .state_out(st_a),
      .rej(rej_a), .err_cnt(err_a), .fault(flt_a));

   guarded_mode_fsm #(.STATE_W(3), .NUM_STATES(8), .MAX_ERR(4), .ERR_W(4)) dut_b (
      .clk(clk), .rst_n(rst_b), .req_valid(v_b), .req_state(rs_b),
      .req_ready(rdy_b), .clr_fault(clr_b), .state_out(st_b),
      .rej(rej_b), .err_cnt(err_b), .fault(flt_b));

   function automatic vec_t mk(int r, int v, int rs, int c, int st, int rdy,
                               int rj, int err, int f);
      vec_t x;
      x.rst_n = r[0]; x.v = v[0]; x.rs = rs[2:0]; x.clr = c[0];
      x.st = st[2:0]; x.rdy = rdy[0]; x.rej = rj[0]; x.err = err[3:0]; x.flt = f[0];
      return x;
   endfunction

   task automatic cmp(input string name, input int idx, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
   endtask

   // Drive at negedge, sample 1ns after the following posedge.
   task automatic apply(input vec_t x, input bit sel_b, input string tag, input int idx);
      @(negedge clk);
      if (!sel_b) begin
         rst_a = x.rst_n; v_a = x.v; rs_a = x.rs; clr_a = x.clr;
      end else begin
         rst_b = x.rst_n; v_b = x.v; rs_b = x.rs; clr_b = x.clr;
      end
      @(posedge clk);
      #1;
      if (!sel_b) begin
         cmp({tag, ".state"}, idx, int'(st_a), int'(x.st));
         cmp({tag, ".ready"}, idx, int'(rdy_a), int'(x.rdy));
         cmp({tag, ".rej"}, idx, int'(rej_a), int'(x.rej));
         cmp({tag, ".err"}, idx, int'(err_a), int'(x.err));
         cmp({tag, ".fault"}, idx, int'(flt_a), int'(x.flt));
      end else begin
         cmp({tag, ".state"}, idx, int'(st_b), int'(x.st));
         cmp({tag, ".ready"}, idx, int'(rdy_b), int'(x.rdy));
         cmp({tag, ".rej"}, idx, int'(rej_b), int'(x.rej));
         cmp({tag, ".err"}, idx, int'(err_b), int'(x.err));
         cmp({tag, ".fault"}, idx, int'(flt_b), int'(x.flt));
      end
   endtask

   vec_t tab[$];

   initial begin
      //            rst v rs clr   st rdy rej err flt
      tab.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0)); // reset state
      tab.push_back(mk(1, 1, 3, 0,  3, 0, 0, 0, 0)); // IDLE->3
      tab.push_back(mk(1, 0, 0, 0,  3, 1, 0, 0, 0));
      tab.push_back(mk(1, 1, 7, 0,  3, 0, 1, 1, 0)); // out of range
      tab.push_back(mk(1, 0, 0, 0,  3, 1, 0, 1, 0)); // rej one cycle only
      tab.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0));
      tab.push_back(mk(1, 1, 1, 0,  1, 0, 0, 0, 0));
      tab.push_back(mk(1, 0, 0, 0,  1, 1, 0, 0, 0));
      tab.push_back(mk(1, 1, 2, 0,  2, 0, 0, 0, 0));
      tab.push_back(mk(1, 0, 0, 0,  2, 1, 0, 0, 0));
      tab.push_back(mk(1, 1, 4, 0,  2, 0, 1, 1, 0)); // skip-over illegal
      tab.push_back(mk(1, 1, 5, 0,  2, 1, 0, 1, 0)); // not ready: ignored
      tab.push_back(mk(1, 1, 5, 0,  2, 0, 1, 2, 0)); // FAULT target illegal
      tab.push_back(mk(1, 0, 0, 0,  2, 1, 0, 2, 0));
      tab.push_back(mk(1, 1, 2, 0,  2, 0, 1, 3, 0)); // self request illegal
      tab.push_back(mk(1, 0, 0, 0,  2, 1, 0, 3, 0));
      tab.push_back(mk(1, 1, 0, 0,  0, 0, 0, 3, 0)); // OP2->IDLE legal
      tab.push_back(mk(1, 0, 0, 0,  0, 1, 0, 3, 0));
      tab.push_back(mk(1, 1, 0, 0,  5, 0, 1, 4, 1)); // fourth error: FAULT
      tab.push_back(mk(1, 1, 1, 0,  5, 0, 0, 4, 1)); // requests ignored
      tab.push_back(mk(1, 1, 2, 0,  5, 0, 0, 4, 1));
      tab.push_back(mk(1, 0, 0, 1,  0, 1, 0, 0, 0)); // clear fault
      tab.push_back(mk(1, 0, 0, 1,  0, 1, 0, 0, 0)); // clr outside FAULT
      tab.push_back(mk(1, 1, 1, 1,  1, 0, 0, 0, 0));
      tab.push_back(mk(1, 0, 0, 0,  1, 1, 0, 0, 0));
      tab.push_back(mk(0, 1, 2, 0,  0, 1, 0, 0, 0)); // reset beats legal req
      tab.push_back(mk(1, 0, 0, 0,  0, 1, 0, 0, 0));
      tab.push_back(mk(1, 1, 0, 0,  0, 0, 1, 1, 0));
      tab.push_back(mk(1, 0, 0, 0,  0, 1, 0, 1, 0));
      tab.push_back(mk(1, 1, 0, 0,  0, 0, 1, 2, 0));
      tab.push_back(mk(1, 0, 0, 0,  0, 1, 0, 2, 0));
      tab.push_back(mk(1, 1, 0, 0,  0, 0, 1, 3, 0));
      tab.push_back(mk(1, 0, 0, 0,  0, 1, 0, 3, 0));
      tab.push_back(mk(0, 1, 0, 0,  0, 1, 0, 0, 0)); // reset beats fault entry
      tab.push_back(mk(1, 0, 0, 0,  0, 1, 0, 0, 0));

      for (int i = 0; i < tab.size(); i++) apply(tab[i], 1'b0, "a", i);

      // Eight-state build: 7 is FAULT, walk OP1..OP6 then hit the top.
      apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1, "b_rst", 0);
      apply(mk(1, 1, 7, 0, 0, 0, 1, 1, 0), 1'b1, "b_req7", 0);
      apply(mk(1, 0, 0, 0, 0, 1, 0, 1, 0), 1'b1, "b_gap", 0);
      for (int s = 1; s <= 6; s++) begin
         apply(mk(1, 1, s, 0, s, 0, 0, 1, 0), 1'b1, "b_walk", s);
         apply(mk(1, 0, 0, 0, s, 1, 0, 1, 0), 1'b1, "b_gap", s);
      end
      apply(mk(1, 1, 7, 0, 6, 0, 1, 2, 0), 1'b1, "b_top", 0);
      apply(mk(1, 0, 0, 0, 6, 1, 0, 2, 0), 1'b1, "b_top_gap", 0);
      apply(mk(1, 1, 5, 0, 5, 0, 0, 2, 0), 1'b1, "b_down", 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/guarded_mode_fsm.md
GUARDED_MODE_FSM -- requirements
Module: guarded_mode_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 3, width of state encoding and request field.
REQ-002 SHALL have parameter NUM_STATES, default 6, count of encoded states 0..NUM_STATES-1; legal range 3 <= NUM_STATES <= 2**STATE_W.
REQ-003 SHALL have parameter MAX_ERR, default 4, illegal-request count that forces FAULT; legal range 1..(2**ERR_W)-1.
REQ-004 SHALL have parameter ERR_W, default 4, width of the error counter.
REQ-005 clk  input  1  clock, all logic rising-edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  1  a state-change request is present.
REQ-008 req_state  input  STATE_W  requested target state.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 clr_fault  input  1  request exit from FAULT; honoured only in FAULT.
REQ-011 state_out  output  STATE_W  current state (registered).
REQ-012 rej  output  1  one-cycle pulse: the previous accepted request was rejected.
REQ-013 err_cnt  output  ERR_W  saturating count of rejected requests since reset or fault clear.
REQ-014 fault  output  1  high while in FAULT.

Function
REQ-015 Encoding SHALL be: IDLE=0, operational states OP1..OPk = 1..NUM_STATES-2, FAULT = NUM_STATES-1.
REQ-016 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-017 req_ready SHALL be low in FAULT and low for exactly one cycle after any accepted request; high otherwise.
REQ-018 req_state SHALL be compared at full STATE_W width; no truncation, no modulo.
REQ-019 An accepted request SHALL be legal only if: from IDLE, target in 1..NUM_STATES-2; from OPi, target is IDLE, OPi-1 (i>1) or OPi+1 (i<NUM_STATES-2).
REQ-020 A request for the current state SHALL be illegal.
REQ-021 Targets >= NUM_STATES or equal to FAULT SHALL be illegal.
REQ-022 Legal accepted request: state_out SHALL equal req_state on the edge after acceptance (latency 1); err_cnt unchanged.
REQ-023 Illegal accepted request: state unchanged, rej pulses high for the cycle after acceptance, err_cnt increments by 1, saturating at 2**ERR_W-1.
REQ-024 When an illegal request raises err_cnt to MAX_ERR, state SHALL move to FAULT on that same edge; fault high from then on.
REQ-025 In FAULT, req_valid SHALL be ignored; no rej pulse, no err_cnt change.
REQ-026 In FAULT, clr_fault high on an edge SHALL move state to IDLE, clear err_cnt to 0 and drop fault on that edge; req_ready rises the following cycle.
REQ-027 clr_fault outside FAULT SHALL have no effect.
REQ-028 Any unencoded state register value (>= NUM_STATES) SHALL transition to FAULT on the next edge.
REQ-029 rej SHALL never be high in two consecutive cycles.

Reset
REQ-030 When rst_n is low on a rising edge: state_out=0 (IDLE), err_cnt=0, rej=0, fault=0, req_ready=1 in the following cycle.
REQ-031 Reset SHALL take priority over requests, clr_fault and fault entry on the same edge, including mid-operation.

Verification
REQ-032 After reset, req 3 accepted -> state_out=3 next cycle, req_ready=0 for one cycle, rej=0, err_cnt=0.
REQ-033 State 3, req 7 (out of range, defaults) -> state_out stays 3, rej pulse one cycle, err_cnt=1.
REQ-034 State 2, requests 4, 5, 2, 0 each accepted with ready gaps -> first three rejected (err_cnt 1,2,3), fourth legal -> state_out=0.
REQ-035 Four illegal requests (MAX_ERR=4) -> on fourth, state_out=5, fault=1, req_ready=0; further req_valid ignored; clr_fault -> state_out=0, err_cnt=0, fault=0.
REQ-036 rst_n low in the same cycle as an accepted legal request from state 1 to 2 -> state_out=0, err_cnt=0, no rej.
REQ-037 NUM_STATES=8, STATE_W=3: req 7 from IDLE rejected; OP1..OP6 walk 1->2->...->6 all accepted, req 7 from 6 rejected.
